// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
//
// Oversampling UART receive front end. It synchronises the raw serial pin,
// finds start edges, and recovers 8N1 frames (8E1 when UART_RX_PARITY_EN is
// defined). Each bit is decided by a 3-sample majority vote around mid-bit.
// Received bytes sit in a one-entry valid/ready output register that feeds the
// RX FIFO write side. Framing, break and overrun conditions are reported as
// single-cycle pulses.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : adds a parity bit after the data (even parity) and the
//               parity_err_o port; frames are 11 bits long.
//   undefined : plain 8N1, no parity_err_o port.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   uart_rx_i     asynchronous serial input, idles high
//   rx_valid_o    output register holds a byte
//   rx_ready_i    consumer accepts the byte this cycle
//   rx_data_o     received byte (LSB first on the line)
//   frame_err_o   pulse: stop bit sampled 0 with non-zero data
//   break_o       pulse: stop bit sampled 0 with all-zero data
//   overrun_o     pulse: byte completed while the output register was full
//   parity_err_o  pulse: parity mismatch on a good-stop frame (parity build)
//   busy_o        receiver is inside a frame
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115_200,
    parameter int Oversample     = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_rx_i,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic [7:0] rx_data_o,
    output logic       frame_err_o,
    output logic       break_o,
    output logic       overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       busy_o
);

    localparam int DivRatio = ClockFrequency / (BaudRate * Oversample);
    localparam int TickW    = (DivRatio > 1) ? $clog2(DivRatio) : 1;
    localparam int SampW    = $clog2(Oversample);

    generate
        if (DivRatio < 1) begin : g_div_check
            $error("uart_rx_sampler: clock too slow for BaudRate*Oversample");
        end
        if ((Oversample % 2) != 0 || Oversample < 8) begin : g_os_check
            $error("uart_rx_sampler: Oversample must be even and >= 8");
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Synchroniser: stages 0/1 resolve metastability, stage 2 is the
    // previous synced value for falling-edge detection. Reset to idle-high
    // so no phantom start edge appears after reset.
    // ---------------------------------------------------------------------
    logic sync_reg [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk_i) begin
                    if (rst_i) sync_reg[gi] <= 1'b1;
                    else       sync_reg[gi] <= uart_rx_i;
                end
            end else begin : g_rest
                always_ff @(posedge clk_i) begin
                    if (rst_i) sync_reg[gi] <= 1'b1;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    logic rx_sync;
    logic rx_fall;
    assign rx_sync = sync_reg[1];
    assign rx_fall = sync_reg[2] & ~sync_reg[1];

    // ---------------------------------------------------------------------
    // Free-running oversample tick. It is never realigned to the start edge;
    // the sample counter provides the per-frame phase instead.
    // ---------------------------------------------------------------------
    logic [TickW-1:0] tick_cnt_reg;
    logic             tick;
    assign tick = (tick_cnt_reg == TickW'(DivRatio - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || tick) tick_cnt_reg <= '0;
        else               tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end

    // ---------------------------------------------------------------------
    // Receive state machine, sample counter and output register.
    // ---------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t           state_reg;
    logic [SampW-1:0] samp_cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic             samp_a_reg;
    logic             samp_b_reg;
    logic             rx_valid_reg;
    logic [7:0]       rx_data_reg;
    logic             frame_err_reg;
    logic             break_reg;
    logic             overrun_reg;
`ifdef UART_RX_PARITY_EN
    logic             parity_bit_reg;
    logic             parity_err_reg;
`endif

    // The third sample is the live synced line at the decision count.
    logic vote_point;
    logic voted;
    assign vote_point = tick && (samp_cnt_reg == SampW'(Oversample / 2 + 1));
    assign voted      = (samp_a_reg & samp_b_reg) | (samp_a_reg & rx_sync) |
                        (samp_b_reg & rx_sync);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            samp_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            samp_a_reg     <= 1'b0;
            samp_b_reg     <= 1'b0;
            rx_valid_reg   <= 1'b0;
            rx_data_reg    <= '0;
            frame_err_reg  <= 1'b0;
            break_reg      <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            frame_err_reg <= 1'b0;
            break_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
            // Handshake; a delivery later in this block overrides the clear.
            if (rx_valid_reg && rx_ready_i) rx_valid_reg <= 1'b0;

            if (tick) begin
                if (samp_cnt_reg == SampW'(Oversample - 1)) samp_cnt_reg <= '0;
                else samp_cnt_reg <= samp_cnt_reg + 1'b1;
                if (samp_cnt_reg == SampW'(Oversample / 2 - 1)) samp_a_reg <= rx_sync;
                if (samp_cnt_reg == SampW'(Oversample / 2))     samp_b_reg <= rx_sync;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (rx_fall) begin
                        samp_cnt_reg <= '0;
                        state_reg    <= ST_START;
                    end
                end
                ST_START: begin
                    if (vote_point) begin
                        bit_cnt_reg <= '0;
                        // A high vote means the edge was a glitch.
                        state_reg   <= voted ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (vote_point) begin
                        shift_reg   <= {voted, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= ST_PARITY;
`else
                            state_reg <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (vote_point) begin
                        parity_bit_reg <= voted;
                        state_reg      <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (vote_point) begin
                        // Back to IDLE at once so the next start edge, which
                        // can arrive half a bit from now, is not missed.
                        state_reg <= ST_IDLE;
                        if (voted) begin
                            if (rx_valid_reg && !rx_ready_i) begin
                                overrun_reg <= 1'b1;
                            end else begin
                                rx_valid_reg <= 1'b1;
                                rx_data_reg  <= shift_reg;
                            end
`ifdef UART_RX_PARITY_EN
                            parity_err_reg <= parity_bit_reg ^ (^shift_reg);
`endif
                        end else if (shift_reg == 8'h00) begin
                            break_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rx_valid_o  = rx_valid_reg;
    assign rx_data_o   = rx_data_reg;
    assign frame_err_o = frame_err_reg;
    assign break_o     = break_reg;
    assign overrun_o   = overrun_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_reg;
`endif
    assign busy_o      = (state_reg != ST_IDLE);

endmodule
